// File: rtl/alu_sched.sv
// alu_sched: shares one registered ALU between NREQ requesters.
// Accepts one operation per handshake, waits the ALU latency and returns
// result, flags and requester id on a single valid/ready response port.
// Build option: define ALU_SCHED_FIXED_PRIO_EN for fixed (lowest index wins)
// priority; otherwise round-robin arbitration is used.
module alu_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned OPW  = 4,
    parameter int unsigned LAT  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*OPW-1:0]       req_op,
    input  logic [NREQ*8-1:0]         req_a,
    input  logic [NREQ*8-1:0]         req_b,
    output logic [OPW-1:0]            alu_op,
    output logic [7:0]                alu_a,
    output logic [7:0]                alu_b,
    input  logic [31:0]               alu_result,
    input  logic                      alu_cf,
    input  logic                      alu_of,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [31:0]               rsp_result,
    output logic                      rsp_cf,
    output logic                      rsp_zf,
    output logic                      rsp_nf,
    output logic                      rsp_of,
    output logic                      rsp_err,
    output logic                      busy
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
`ifndef ALU_SCHED_FIXED_PRIO_EN
    logic [IDW-1:0]    ptr_q, ptr_d;
`endif
    logic [OPW-1:0]    alu_op_q, alu_op_d;
    logic [7:0]        alu_a_q, alu_a_d;
    logic [7:0]        alu_b_q, alu_b_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [31:0]       rsp_result_q, rsp_result_d;
    logic              rsp_cf_q, rsp_cf_d;
    logic              rsp_zf_q, rsp_zf_d;
    logic              rsp_nf_q, rsp_nf_d;
    logic              rsp_of_q, rsp_of_d;
    logic              rsp_err_q, rsp_err_d;

    logic              grant_found_c;
    logic [IDW-1:0]    grant_id_c;
    logic [OPW-1:0]    sel_op_c;
    logic [7:0]        sel_a_c;
    logic [7:0]        sel_b_c;
    logic              op_ok_c;

    // Arbiter: pick the winning requester among those asserting valid
    always_comb begin : arb
`ifndef ALU_SCHED_FIXED_PRIO_EN
        int unsigned idx;
        idx = 0;
`endif
        grant_found_c = 1'b0;
        grant_id_c    = '0;
`ifdef ALU_SCHED_FIXED_PRIO_EN
        // Scanning downward leaves the lowest valid index as the winner
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[IDW'(i)]) begin
                grant_found_c = 1'b1;
                grant_id_c    = IDW'(i);
            end
        end
`else
        // Search starts just after the last winner so every requester rotates in
        for (int k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_q) + 32'd1 + 32'(k)) % NREQ;
            if (!grant_found_c && req_valid[IDW'(idx)]) begin
                grant_found_c = 1'b1;
                grant_id_c    = IDW'(idx);
            end
        end
`endif
    end

    // Winner's payload and opcode legality (1..10 are real ALU operations)
    always_comb begin : sel
        sel_op_c = req_op[32'(grant_id_c) * OPW +: OPW];
        sel_a_c  = req_a[32'(grant_id_c) * 8 +: 8];
        sel_b_c  = req_b[32'(grant_id_c) * 8 +: 8];
        op_ok_c  = (32'(sel_op_c) >= 32'd1) && (32'(sel_op_c) <= 32'd10);
    end

    // Grant is only visible while idle
    always_comb begin : ready_gen
        req_ready = '0;
        if (state_q == S_IDLE && grant_found_c) begin
            req_ready = NREQ'(1) << grant_id_c;
        end
    end

    // Next-state and register updates for the scheduler FSM
    always_comb begin : fsm_next
        state_d      = state_q;
        cnt_d        = cnt_q;
`ifndef ALU_SCHED_FIXED_PRIO_EN
        ptr_d        = ptr_q;
`endif
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_cf_d     = rsp_cf_q;
        rsp_zf_d     = rsp_zf_q;
        rsp_nf_d     = rsp_nf_q;
        rsp_of_d     = rsp_of_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (grant_found_c) begin
                    rsp_id_d = grant_id_c;
`ifndef ALU_SCHED_FIXED_PRIO_EN
                    ptr_d    = grant_id_c;
`endif
                    if (op_ok_c) begin
                        alu_op_d = sel_op_c;
                        alu_a_d  = sel_a_c;
                        alu_b_d  = sel_b_c;
                        cnt_d    = CW'(LAT);
                        state_d  = S_WAIT;
                    end else begin
                        // Bad opcode: answer directly, ALU inputs untouched
                        rsp_result_d = '0;
                        rsp_cf_d     = 1'b0;
                        rsp_zf_d     = 1'b0;
                        rsp_nf_d     = 1'b0;
                        rsp_of_d     = 1'b0;
                        rsp_err_d    = 1'b1;
                        state_d      = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    rsp_result_d = alu_result;
                    rsp_cf_d     = alu_cf;
                    rsp_of_d     = alu_of;
                    rsp_zf_d     = (alu_result == 32'd0);
                    rsp_nf_d     = alu_result[31];
                    rsp_err_d    = 1'b0;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin : regs
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
            ptr_q        <= IDW'(NREQ - 1);
`endif
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_cf_q     <= 1'b0;
            rsp_zf_q     <= 1'b0;
            rsp_nf_q     <= 1'b0;
            rsp_of_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
`ifndef ALU_SCHED_FIXED_PRIO_EN
            ptr_q        <= ptr_d;
`endif
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_cf_q     <= rsp_cf_d;
            rsp_zf_q     <= rsp_zf_d;
            rsp_nf_q     <= rsp_nf_d;
            rsp_of_q     <= rsp_of_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_cf     = rsp_cf_q;
    assign rsp_zf     = rsp_zf_q;
    assign rsp_nf     = rsp_nf_q;
    assign rsp_of     = rsp_of_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched (NREQ=4, OPW=4, LAT=1) with a one-cycle ALU model.
// ALU model opcodes: 1 ADD, 2 SUB, 3 AND, 10 PASS-A (sets of). Others give 0.
module tb_alu_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [31:0] alu_result;
    logic        alu_cf;
    logic        alu_of;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_cf, rsp_zf, rsp_nf, rsp_of, rsp_err;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0]  last_op;
    logic [7:0]  last_a;
    logic [7:0]  last_b;

    always #5 clk = ~clk;

    alu_sched #(.NREQ(4), .OPW(4), .LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_cf     (alu_cf),
        .alu_of     (alu_of),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_cf     (rsp_cf),
        .rsp_zf     (rsp_zf),
        .rsp_nf     (rsp_nf),
        .rsp_of     (rsp_of),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    // Reference ALU: {of, cf, result}
    function automatic logic [33:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [31:0] sa, sb, r;
        logic [8:0]  s9;
        logic        cf, of;
        sa = {{24{a[7]}}, a};
        sb = {{24{b[7]}}, b};
        r  = 32'd0;
        cf = 1'b0;
        of = 1'b0;
        s9 = {1'b0, a} + {1'b0, b};
        case (op)
            4'd1:  begin r = sa + sb; cf = s9[8]; end
            4'd2:  begin r = sa - sb; cf = (a < b); end
            4'd3:  r = sa & sb;
            4'd10: begin r = sa; of = 1'b1; end
            default: r = 32'd0;
        endcase
        return {of, cf, r};
    endfunction

    // One-cycle registered ALU fed by the scheduler
    always @(posedge clk or posedge rst) begin
        if (rst) {alu_of, alu_cf, alu_result} <= 34'd0;
        else     {alu_of, alu_cf, alu_result} <= alu_fn(alu_op, alu_a, alu_b);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[id*4 +: 4] = op;
        req_a[id*8 +: 8]  = a;
        req_b[id*8 +: 8]  = b;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        last_op   = '0;
        last_a    = '0;
        last_b    = '0;
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask

    // Single-requester transaction; ef = {err, of, nf, zf, cf}; elat counts edges from accept
    task automatic txn(input string tag, input int id, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [31:0] er, input logic [4:0] ef, input int elat);
        int n;
        bit got;
        req_valid     = '0;
        set_req(id, op, a, b);
        req_valid[id] = 1'b1;
        #1;
        got = 1'b0;
        n   = 0;
        while (!got && n < 20) begin
            if (req_ready == (4'd1 << id)) got = 1'b1;
            else begin step(); n++; end
        end
        check({tag, "_grant"}, 32'(got), 32'd1);
        if (!got) begin
            req_valid = '0;
            return;
        end
        step();
        req_valid = '0;
        if (elat > 1) begin
            last_op = op;
            last_a  = a;
            last_b  = b;
        end
        check({tag, "_alu_in"}, {12'd0, alu_op, alu_a, alu_b}, {12'd0, last_op, last_a, last_b});
        n = 1;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(elat));
        check({tag, "_result"}, rsp_result, er);
        check({tag, "_id"}, 32'(rsp_id), 32'(id));
        check({tag, "_flags"}, {27'd0, rsp_err, rsp_of, rsp_nf, rsp_zf, rsp_cf}, {27'd0, ef});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, "_idle"}, {30'd0, busy, rsp_valid}, 32'd0);
    endtask

    initial begin
        int order[5];
        int exp_order[5];
        int g, cyc, last_cyc, n;
        bit seen;
        logic [31:0] snap;

        do_reset();

        // Reset state
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_ctl", {30'd0, rsp_valid, busy}, 32'd0);
        check("rst_rsp", rsp_result, 32'd0);
        check("rst_rsp_misc", {25'd0, rsp_id, rsp_err, rsp_of, rsp_nf, rsp_zf, rsp_cf}, 32'd0);
        check("rst_alu", {12'd0, alu_op, alu_a, alu_b}, 32'd0);

        // Directed ALU traffic
        txn("add",   0, 4'd1,  8'h7F, 8'h01, 32'h0000_0080, 5'b00000, 3);
        txn("sub",   1, 4'd2,  8'h80, 8'h01, 32'hFFFF_FF7F, 5'b00100, 3);
        txn("and",   3, 4'd3,  8'h0F, 8'hF0, 32'h0000_0000, 5'b00010, 3);
        txn("addc",  2, 4'd1,  8'hFF, 8'h01, 32'h0000_0000, 5'b00011, 3);
        txn("pass",  1, 4'd10, 8'h85, 8'h00, 32'hFFFF_FF85, 5'b01100, 3);
        txn("inv",   2, 4'hF,  8'h12, 8'h34, 32'h0000_0000, 5'b10000, 1);
        txn("inv0",  0, 4'h0,  8'h55, 8'h66, 32'h0000_0000, 5'b10000, 1);

        // Arbitration with all requesters pending and responses always accepted
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 4'd1, 8'(i), 8'h10);
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        #1;
`ifdef ALU_SCHED_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        order    = '{-1, -1, -1, -1, -1};
        g        = 0;
        cyc      = 0;
        last_cyc = 0;
        while (g < 5 && cyc < 100) begin
            if (req_ready != 4'd0) begin
                check("rr_onehot", 32'($countones(req_ready)), 32'd1);
                for (int i = 0; i < 4; i++) if (req_ready[i]) order[g] = i;
                if (g > 0) check("rr_interval", 32'(cyc - last_cyc), 32'd4);
                last_cyc = cyc;
                g++;
            end
            step();
            cyc++;
        end
        check("rr_count", 32'(g), 32'd5);
        for (int k = 0; k < 5; k++) check($sformatf("rr_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
        req_valid = '0;
        n = 0;
        while (busy && n < 20) begin step(); n++; end
        check("rr_drain", 32'(busy), 32'd0);
        rsp_ready = 1'b0;

        // Backpressure: response held while rsp_ready is low
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 4'd1, 8'(i), 8'h01);
        req_valid = 4'hF;
        #1;
        check("bp_grant0", 32'(req_ready), 32'h1);
        step();
        check("bp_wait_ready", 32'(req_ready), 32'd0);
        n = 0;
        while (!rsp_valid && n < 20) begin step(); n++; end
        snap = rsp_result;
        check("bp_result", snap, 32'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("bp_hold%0d", k),
                  {rsp_result[27:0], 1'b0, rsp_valid, rsp_id},
                  {snap[27:0], 1'b0, 1'b1, 2'd0});
            check($sformatf("bp_ready%0d", k), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
`ifdef ALU_SCHED_FIXED_PRIO_EN
        check("bp_next_grant", 32'(req_ready), 32'h1);
`else
        check("bp_next_grant", 32'(req_ready), 32'h2);
`endif
        step();
        req_valid = '0;
        n = 0;
        while (!rsp_valid && n < 20) begin step(); n++; end
`ifdef ALU_SCHED_FIXED_PRIO_EN
        check("bp_next_rsp", {rsp_result[29:0], rsp_id}, {30'd1, 2'd0});
`else
        check("bp_next_rsp", {rsp_result[29:0], rsp_id}, {30'd2, 2'd1});
`endif
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("bp_idle", 32'(busy), 32'd0);

        // Reset while waiting on the ALU
        do_reset();
        set_req(1, 4'd1, 8'h05, 8'h05);
        req_valid = 4'b0010;
        #1;
        check("mr_grant", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        check("mr_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mr_abort", {15'd0, busy, rsp_valid, alu_op, alu_a, 4'd0}, 32'd0);
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (rsp_valid) seen = 1'b1;
        end
        check("mr_no_rsp", 32'(seen), 32'd0);
        set_req(0, 4'd1, 8'h01, 8'h01);
        set_req(3, 4'd1, 8'h02, 8'h02);
        req_valid = 4'b1001;
        #1;
        check("mr_first", 32'(req_ready), 32'h1);
        req_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
